// File: rtl/riscv_imm_pkg.sv
// Shared RISC-V opcode constants, immediate-format codes and stage states
// for the registered immediate generator.
package riscv_imm_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_R     = 3'd6,
        FMT_SHAMT = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    // SLLI/SRLI/SRAI share the OP-IMM opcode; funct3 picks them out.
    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Pure combinational decode of a 32-bit RISC-V word into its
// sign/zero-extended immediate, format code and illegal-opcode flag.
module imm_extract
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OPC_OP_IMM: begin
                if (is_shift(funct3)) begin
                    fmt = FMT_SHAMT;
                    if (XLEN == 64) imm = XLEN'(instr[25:20]);
                    else            imm = XLEN'(instr[24:20]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_OP_IMM_32: begin
                // The *W forms only exist on RV64.
                if (XLEN == 64) begin
                    if (is_shift(funct3)) begin
                        fmt = FMT_SHAMT;
                        imm = XLEN'(instr[24:20]);
                    end else begin
                        fmt = FMT_I;
                        imm = XLEN'($signed(instr[31:20]));
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            OPC_OP_32: begin
                if (XLEN == 64) fmt = FMT_R;
                else            illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generator pipeline stage with a two-entry skid so
// in_ready depends only on local state, never combinationally on out_ready.
module imm_gen_stage
    import riscv_imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output fmt_t             out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    stage_state_t state_reg, state_next;

    logic [XLEN-1:0]  dec_imm;
    fmt_t             dec_fmt;
    logic             dec_illegal;

    logic [XLEN-1:0]  out_imm_reg, skid_imm_reg;
    fmt_t             out_fmt_reg, skid_fmt_reg;
    logic             out_illegal_reg, skid_illegal_reg;
    logic [TAG_W-1:0] out_tag_reg, skid_tag_reg;

    logic accept, pop;
    logic load_out_new, load_out_skid, load_skid;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_ready  = (state_reg != ST_TWO);
    assign out_valid = (state_reg != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_next    = state_reg;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next   = ST_ONE;
                    load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Skid always holds the younger word, so it refills out first.
                if (pop) begin
                    state_next    = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_EMPTY;
            out_imm_reg      <= '0;
            out_fmt_reg      <= FMT_NONE;
            out_illegal_reg  <= 1'b0;
            out_tag_reg      <= '0;
            skid_imm_reg     <= '0;
            skid_fmt_reg     <= FMT_NONE;
            skid_illegal_reg <= 1'b0;
            skid_tag_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (load_out_new) begin
                out_imm_reg     <= dec_imm;
                out_fmt_reg     <= dec_fmt;
                out_illegal_reg <= dec_illegal;
                out_tag_reg     <= in_tag;
            end else if (load_out_skid) begin
                out_imm_reg     <= skid_imm_reg;
                out_fmt_reg     <= skid_fmt_reg;
                out_illegal_reg <= skid_illegal_reg;
                out_tag_reg     <= skid_tag_reg;
            end
            if (load_skid) begin
                skid_imm_reg     <= dec_imm;
                skid_fmt_reg     <= dec_fmt;
                skid_illegal_reg <= dec_illegal;
                skid_tag_reg     <= in_tag;
            end
        end
    end

    assign out_imm     = out_imm_reg;
    assign out_fmt     = out_fmt_reg;
    assign out_illegal = out_illegal_reg;
    assign out_tag     = out_tag_reg;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: RV64 decode, backpressure ordering,
// asynchronous reset in the full state, and an RV32 instance.
module tb_imm_gen_stage;
    import riscv_imm_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr;
    logic [7:0]  in_tag, out_tag;
    logic [63:0] out_imm;
    fmt_t        out_fmt;

    logic        v32, rdy32, ov32, ordy32, ill32;
    logic [31:0] instr32, imm32;
    logic [7:0]  tag32, otag32;
    fmt_t        fmt32;

    int checks = 0;
    int errors = 0;

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clock(clock), .reset(reset),
        .in_valid(v32), .in_ready(rdy32), .in_instr(instr32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32), .out_tag(otag32)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // One word through an idle stage with out_ready high: visible after the
    // accepting edge, gone after the next one.
    task automatic send(input string name, input logic [31:0] instr, input logic [7:0] tag,
                        input logic [63:0] eimm, input fmt_t efmt, input logic eill);
        in_instr = instr;
        in_tag   = tag;
        in_valid = 1'b1;
        check({name, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        $display("txn %s instr=0x%08h tag=0x%02h imm=0x%016h fmt=%0d illegal=%0b",
                 name, instr, out_tag, out_imm, out_fmt, out_illegal);
        check({name, ".valid"},   64'(out_valid),   64'd1);
        check({name, ".imm"},     out_imm,          eimm);
        check({name, ".fmt"},     64'(out_fmt),     64'(efmt));
        check({name, ".illegal"}, 64'(out_illegal), 64'(eill));
        check({name, ".tag"},     64'(out_tag),     64'(tag));
        @(posedge clock); #1;
        check({name, ".drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        v32 = 1'b0; instr32 = '0; tag32 = '0; ordy32 = 1'b1;

        // Reset state before any clock edge
        #2;
        check("rst.out_valid",   64'(out_valid),   64'd0);
        check("rst.out_imm",     out_imm,          64'd0);
        check("rst.out_fmt",     64'(out_fmt),     64'(FMT_NONE));
        check("rst.out_illegal", 64'(out_illegal), 64'd0);
        check("rst.out_tag",     64'(out_tag),     64'd0);
        check("rst.in_ready",    64'(in_ready),    64'd1);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        send("ld",   32'hFF813283, 8'h01, 64'hFFFF_FFFF_FFFF_FFF8, FMT_I,     1'b0);
        send("sd",   32'h00513823, 8'h02, 64'h0000_0000_0000_0010, FMT_S,     1'b0);
        send("beq",  32'hFE000EE3, 8'h03, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B,     1'b0);
        send("lui",  32'h800000B7, 8'h04, 64'hFFFF_FFFF_8000_0000, FMT_U,     1'b0);
        send("srai", 32'h4030D093, 8'h05, 64'h0000_0000_0000_0003, FMT_SHAMT, 1'b0);
        send("bad",  32'h0000007F, 8'h06, 64'h0,                   FMT_NONE,  1'b1);
        send("add",  32'h00B50533, 8'h07, 64'h0,                   FMT_R,     1'b0);
        send("jal",  32'hFFDFF06F, 8'h08, 64'hFFFF_FFFF_FFFF_FFFC, FMT_J,     1'b0);
        send("addiw",32'h0010009B, 8'h09, 64'h0000_0000_0000_0001, FMT_I,     1'b0);

        // Backpressure: two words fill out+skid, third is refused
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'hFF813283; in_tag = 8'hA1;
        @(posedge clock); #1;
        in_instr = 32'h00513823; in_tag = 8'hA2;
        @(posedge clock); #1;
        in_instr = 32'hFE000EE3; in_tag = 8'hA3;
        check("bp.in_ready_full", 64'(in_ready), 64'd0);
        check("bp.head_tag",      64'(out_tag),  64'hA1);
        @(posedge clock); #1;
        check("bp.hold_tag",      64'(out_tag),  64'hA1);
        check("bp.hold_imm",      out_imm,       64'hFFFF_FFFF_FFFF_FFF8);
        check("bp.still_full",    64'(in_ready), 64'd0);
        out_ready = 1'b1;
        $display("txn bp pop tag=0x%02h", out_tag);
        @(posedge clock); #1;
        $display("txn bp pop tag=0x%02h", out_tag);
        check("bp.second_tag",    64'(out_tag),  64'hA2);
        check("bp.second_imm",    out_imm,       64'h10);
        check("bp.ready_again",   64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        $display("txn bp pop tag=0x%02h", out_tag);
        check("bp.third_tag",     64'(out_tag),  64'hA3);
        check("bp.third_fmt",     64'(out_fmt),  64'(FMT_B));
        check("bp.third_valid",   64'(out_valid), 64'd1);
        @(posedge clock); #1;
        check("bp.empty",         64'(out_valid), 64'd0);

        // Asynchronous reset while both entries are full
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h800000B7; in_tag = 8'hB1;
        @(posedge clock); #1;
        in_tag = 8'hB2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("rst2.pre_full", 64'(in_ready), 64'd0);
        #1 reset = 1'b1;
        #1;
        $display("txn async reset in full state");
        check("rst2.out_valid", 64'(out_valid), 64'd0);
        check("rst2.in_ready",  64'(in_ready),  64'd1);
        check("rst2.out_tag",   64'(out_tag),   64'd0);
        check("rst2.out_fmt",   64'(out_fmt),   64'(FMT_NONE));
        @(negedge clock); reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("rst2.stays_empty", 64'(out_valid), 64'd0);
        send("post_rst", 32'h0000006F, 8'hC1, 64'h0, FMT_J, 1'b0);

        // RV32 instance
        v32 = 1'b1; instr32 = 32'h0000001B; tag32 = 8'hD1;
        @(posedge clock); #1;
        v32 = 1'b0;
        $display("txn rv32 addiw instr=0x0000001b illegal=%0b", ill32);
        check("rv32.w_illegal", 64'(ill32),  64'd1);
        check("rv32.w_fmt",     64'(fmt32),  64'(FMT_NONE));
        check("rv32.w_imm",     64'(imm32),  64'd0);
        @(posedge clock); #1;
        v32 = 1'b1; instr32 = 32'hFFF00093; tag32 = 8'hD2;
        @(posedge clock); #1;
        v32 = 1'b0;
        $display("txn rv32 addi instr=0xfff00093 imm=0x%08h", imm32);
        check("rv32.addi_imm",  64'(imm32),  64'h0000_0000_FFFF_FFFF);
        check("rv32.addi_fmt",  64'(fmt32),  64'(FMT_I));
        check("rv32.addi_tag",  64'(otag32), 64'hD2);
        @(posedge clock); #1;
        check("rv32.drained",   64'(ov32),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
